// File: rtl/d_trans_b.sv
// Sequential decimal-to-binary converter: four 7-bit digit fields (thousands first)
// are folded into a 14-bit binary value by multiply-by-ten-and-add, one digit per clock.
module d_trans_b (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [27:0] digits,
  output logic        busy,
  output logic        valid,
  output logic [13:0] distance,
  output logic        err
);

  // Handshake: start is honoured only in IDLE; busy is high whenever the state is
  // not IDLE; valid is a one-cycle pulse in DONE, coinciding with the first cycle
  // in which the new distance/err values are visible.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [27:0] shreg;
  logic [13:0] acc, acc_next;
  logic [1:0]  cnt;
  logic        invalid;
  logic [6:0]  top;

  function automatic logic field_bad(input logic [6:0] f);
    return f > 7'd9;
  endfunction

  // The whole 7-bit field is added; for legal digits bits [6:4] are zero, and for
  // illegal ones the accumulated value is discarded anyway.
  assign top      = shreg[27:21];
  assign acc_next = (acc << 3) + (acc << 1) + {7'd0, top};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (cnt == 2'd3) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      invalid  <= 1'b0;
      distance <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= digits;
            acc     <= '0;
            cnt     <= '0;
            invalid <= field_bad(digits[27:21]) | field_bad(digits[20:14]) |
                       field_bad(digits[13:7])  | field_bad(digits[6:0]);
          end
        end
        CONV: begin
          acc   <= acc_next;
          shreg <= {shreg[20:0], 7'd0};
          cnt   <= cnt + 2'd1;
          // Last digit: publish the result on the edge that enters DONE.
          if (cnt == 2'd3) begin
            distance <= invalid ? 14'd0 : acc_next;
            err      <= invalid;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign valid = (state == DONE);

endmodule

// File: tb/tb_d_trans_b.sv
// Directed bench for d_trans_b: handshake timing, invalid digits, ignored starts,
// reset abort and a full 0000-9999 sweep.
module tb_d_trans_b;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [27:0] digits;
  logic        busy;
  logic        valid;
  logic [13:0] distance;
  logic        err;

  int total = 0;
  int bad   = 0;
  int vcount = 0;
  int dbl = 0;
  int cyc = 0;
  logic valid_prev = 1'b0;

  d_trans_b dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .digits   (digits),
    .busy     (busy),
    .valid    (valid),
    .distance (distance),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid) vcount <= vcount + 1;
    if (valid && valid_prev) dbl <= dbl + 1;
    valid_prev <= valid;
  end

  function automatic logic [27:0] pack(input int th, input int hu, input int te, input int un);
    logic [6:0] a, b, c, d;
    a = 7'(th); b = 7'(hu); c = 7'(te); d = 7'(un);
    return {a, b, c, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One conversion; leaves the bench at the negedge after E4 (full=0) or after E5 (full=1).
  task automatic run(input logic [27:0] d, input int exp_d, input logic exp_e,
                     input string tag, input bit full);
    int n;
    @(negedge clk); digits = d; start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (full) check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    n = 0;
    while (!valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd4);
    check({tag, " distance"}, 32'(distance), 32'(exp_d));
    check({tag, " err"}, 32'(err), 32'(exp_e));
    if (full) begin
      check({tag, " busy_at_valid"}, 32'(busy), 32'd1);
      @(negedge clk);
      check({tag, " valid_drop"}, 32'(valid), 32'd0);
      check({tag, " busy_drop"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int vstart, t0, t1, seen;
    rst = 1'b1; start = 1'b0; digits = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset distance", 32'(distance), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;

    run(pack(1, 2, 3, 4), 1234, 1'b0, "d1234", 1'b1);
    run(pack(9, 9, 9, 9), 9999, 1'b0, "d9999", 1'b1);
    run(pack(0, 0, 0, 0), 0, 1'b0, "d0000", 1'b1);
    run(pack(0, 0, 0, 12), 0, 1'b1, "unit12", 1'b1);
    run(pack(0, 0, 4, 2), 42, 1'b0, "d0042", 1'b1);
    run(pack(0, 0, 80, 0), 0, 1'b1, "ten80", 1'b1);
    run(pack(0, 64, 0, 3), 0, 1'b1, "hund64", 1'b1);

    // start at E2 and E5 with different digits must be ignored
    vstart = vcount;
    @(negedge clk); digits = pack(3, 1, 4, 1); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); digits = pack(2, 7, 1, 8); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ign valid_at_e4", 32'(valid), 32'd1);
    check("ign distance", 32'(distance), 32'd3141);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("ign busy_after_e5", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    check("ign pulse_count", 32'(vcount - vstart), 32'd1);
    check("ign distance_hold", 32'(distance), 32'd3141);

    // start held high: pulses six cycles apart
    @(negedge clk); digits = pack(1, 1, 1, 1); start = 1'b1;
    seen = 0; t0 = 0; t1 = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (valid) begin
        if (seen == 0) t0 = cyc;
        else if (seen == 1) t1 = cyc;
        seen++;
      end
    end
    start = 1'b0;
    check("held pulses", 32'(seen), 32'd2);
    check("held spacing", 32'(t1 - t0), 32'd6);
    check("held distance", 32'(distance), 32'd1111);
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    check("held idle", 32'(busy), 32'd0);

    // reset at E3 aborts the conversion
    @(negedge clk); digits = pack(6, 6, 6, 6); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort valid", 32'(valid), 32'd0);
    check("abort distance", 32'(distance), 32'd0);
    check("abort err", 32'(err), 32'd0);
    vstart = vcount;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort no_pulse", 32'(vcount - vstart), 32'd0);
    run(pack(5, 0, 0, 7), 5007, 1'b0, "d5007", 1'b1);

    // exhaustive sweep
    for (int v = 0; v < 10000; v++)
      run(pack(v / 1000, (v / 100) % 10, (v / 10) % 10, v % 10), v, 1'b0, "sweep", 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("no_double_valid", 32'(dbl), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
